// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// The FSM state type lives here so that the RTL and any checkers use one encoding.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder cell, purely combinational.
// This is the single arithmetic cell that the sequencer time-shares.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full adder cell is reused for WIDTH cycles,
// LSB first, with a start/busy/done handshake toward the requester.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_next_s;

    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Fresh sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
    assign s_next_s = WIDTH'({fa_s, s_sr_q} >> 1'b1);

    // Next-state, datapath and output-register decode.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1'b1;
                b_sr_d = b_sr_q >> 1'b1;
                s_sr_d = s_next_s;
                c_d    = fa_cout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_next_s;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: drivers push expected results,
// monitors pop and compare on every done pulse (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         done_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8), .CNT_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                check("spurious_done8", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e.sum));
                check("cout8", 32'(cout8), 32'(e.cout));
                check("latency8", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("spurious_done1", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                check("sum1", 32'(sum1), 32'(e.sum));
                check("cout1", 32'(cout1), 32'(e.cout));
                check("latency1", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 50 && busy8; i++) @(negedge clk);
        if (busy8) check("idle_timeout8", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle1();
        for (int i = 0; i < 50 && busy1; i++) @(negedge clk);
        if (busy1) check("idle_timeout1", 32'(busy1), 32'd0);
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [7:0] es, input logic ec, input bit hold, input bit push);
        exp_t e;
        wait_idle8();
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        if (push) begin
            e.sum = es; e.cout = ec; e.done_cyc = cyc + 1 + W;
            q8.push_back(e);
        end
        @(negedge clk);
        if (!hold) start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic issue1(input logic av, input logic bv, input logic cv);
        exp_t e;
        wait_idle1();
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        e.sum = {7'd0, av ^ bv ^ cv};
        e.cout = (av & bv) | (av & cv) | (bv & cv);
        e.done_cyc = cyc + 1 + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        a1 = ~av; b1 = ~bv; cin1 = ~cv;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("queue8_empty", 32'(q8.size()), 32'd0);
        check("queue1_empty", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic       rc;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Completed op leaves a nonzero result, then reset aborts the next one mid-run.
        issue8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1);
        drain();
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_busy", 32'(busy8), 32'd0);
        check("midrun_rst_done", 32'(done8), 32'd0);
        check("midrun_rst_sum", 32'(sum8), 32'd0);
        check("midrun_rst_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        issue8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        issue8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);

        // start held high: each accept lands exactly 10 cycles after the previous.
        issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, 1'b1);
        issue8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        issue8(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
        issue8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8;
            @(negedge clk);
            check("hold_sum", 32'(sum8), 32'h00);
            check("hold_cout", 32'(cout8), 32'd1);
            check("hold_done", 32'(done8), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            issue1(i[2], i[1], i[0]);
        end
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            r = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            issue8(ra, rb, rc, r[7:0], r[8], (i % 3) == 0, 1'b1);
        end
        start8 = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
